// File: rtl/mad_pkg.sv
// Package for the median / MAD engine.
//   mad_state_t     : controller states
//   SCALE_FRAC_BITS : fractional bits of the Q8.8 sigma factor
//   cnt_w(n)        : width of a counter holding 0..n
//   idx_w(n)        : width of an index 0..n-1 (at least 1 bit)
package mad_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MED_PASS,
      ST_MED_WAIT,
      ST_DEV_PASS,
      ST_DEV_WAIT,
      ST_SCALE,
      ST_OUT_PASS,
      ST_DONE
   } mad_state_t;

   localparam int SCALE_FRAC_BITS = 8;

   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mad_engine_median_select.sv
// median_select: streaming lower-median selector.
// Each accepted beat is inserted in one cycle into a register array kept in
// ascending order; after POPSIZE beats the lower median (sorted index
// (POPSIZE-1)/2) is presented and out_vld is held until clr.
// Ports:
//   clk, rst (async, active-high), clr (sync restart)
//   in_vld / in_data  : sample stream, DATA_WIDTH bits
//   out_vld           : median available (sticky until clr)
//   out_median        : lower median, DATA_WIDTH bits
module median_select
   import mad_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int POPSIZE    = 100
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  in_vld,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_vld,
   output logic [DATA_WIDTH-1:0] out_median
);

   localparam int CW = cnt_w(POPSIZE);

   logic [DATA_WIDTH-1:0] srt [POPSIZE];
   logic [DATA_WIDTH-1:0] nxt [POPSIZE];
   logic [CW-1:0]         fill;

   // Parallel insertion: a filled slot whose value is <= in_data stays put;
   // otherwise it takes in_data (if its left neighbour is <= in_data) or
   // the left neighbour shifted right by one.
   for (genvar g = 0; g < POPSIZE; g++) begin : g_slot
      logic stay;
      assign stay = (CW'(g) < fill) && (srt[g] <= in_data);
      if (g == 0) begin : g_first
         assign nxt[g] = stay ? srt[g] : in_data;
      end else begin : g_rest
         assign nxt[g] = stay ? srt[g] :
                         ((srt[g-1] <= in_data) ? in_data : srt[g-1]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         srt     <= '{default: '0};
         fill    <= '0;
         out_vld <= 1'b0;
      end else if (clr) begin
         fill    <= '0;
         out_vld <= 1'b0;
      end else if (in_vld && !out_vld) begin
         srt  <= nxt;
         fill <= fill + CW'(1);
         if (fill == CW'(POPSIZE - 1))
            out_vld <= 1'b1;
      end
   end

   assign out_median = srt[(POPSIZE - 1) / 2];

endmodule

// File: rtl/mad_engine.sv
// mad_engine: per-channel median and median-absolute-deviation engine.
// Pass 1 streams POPSIZE samples of the selected channel into the median
// selector; pass 2 streams |x - median| to obtain the raw MAD, which is then
// scaled by the Q8.8 factor SCALE. Optional macro MAD_OUTLIER_EN adds a third
// pass counting samples with |x - median| > OUTLIER_K * mad_raw.
// Ports:
//   clk, rst (async, active-high)
//   start, ch_sel            : begin a run on channel ch_sel (IDLE only)
//   busy, done               : run in progress / one-cycle completion pulse
//   rd_req, rd_ch, rd_addr   : sample read requests, one per cycle per pass
//   rd_vld, rd_data          : in-order read data, any latency
//   median, mad_raw          : lower median and unscaled MAD
//   mad_scaled               : mad_raw * SCALE, 8 fractional bits
//   below_cnt                : samples strictly below the median
//   outlier_cnt              : outlier count (0 unless MAD_OUTLIER_EN)
module mad_engine
   import mad_pkg::*;
#(
   parameter int          DATA_WIDTH = 8,
   parameter int          POPSIZE    = 100,
   parameter int          NUM_CH     = 4,
   parameter logic [15:0] SCALE      = 16'h017C,
   parameter int          OUTLIER_K  = 3
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     start,
   input  logic [idx_w(NUM_CH)-1:0]                 ch_sel,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     rd_req,
   output logic [idx_w(NUM_CH)-1:0]                 rd_ch,
   output logic [idx_w(POPSIZE)-1:0]                rd_addr,
   input  logic                                     rd_vld,
   input  logic [DATA_WIDTH-1:0]                    rd_data,
   output logic [DATA_WIDTH-1:0]                    median,
   output logic [DATA_WIDTH-1:0]                    mad_raw,
   output logic [DATA_WIDTH+2*SCALE_FRAC_BITS-1:0]  mad_scaled,
   output logic [cnt_w(POPSIZE)-1:0]                below_cnt,
   output logic [cnt_w(POPSIZE)-1:0]                outlier_cnt
);

   localparam int AW = idx_w(POPSIZE);
   localparam int CW = cnt_w(POPSIZE);
   localparam int SW = DATA_WIDTH + 2 * SCALE_FRAC_BITS;

   mad_state_t            state;
   logic [CW-1:0]         beat_cnt;
   logic [DATA_WIDTH-1:0] dev;
   logic                  in_pass;
   logic                  last_beat;
   logic                  sel_in_vld;
   logic                  sel_clr;
   logic                  sel_vld;
   logic [DATA_WIDTH-1:0] sel_in;
   logic [DATA_WIDTH-1:0] sel_med;

   // Larger minus smaller so the deviation never wraps.
   assign dev        = (rd_data > median) ? (rd_data - median) : (median - rd_data);
   assign in_pass    = state inside {ST_MED_PASS, ST_DEV_PASS, ST_OUT_PASS};
   assign last_beat  = in_pass && rd_vld && (beat_cnt == CW'(POPSIZE - 1));
   assign sel_in_vld = rd_vld && (state == ST_MED_PASS || state == ST_DEV_PASS);
   assign sel_in     = (state == ST_MED_PASS) ? rd_data : dev;
   assign sel_clr    = sel_vld && (state == ST_MED_WAIT || state == ST_DEV_WAIT);

   median_select #(
      .DATA_WIDTH (DATA_WIDTH),
      .POPSIZE    (POPSIZE)
   ) u_sel (
      .clk        (clk),
      .rst        (rst),
      .clr        (sel_clr),
      .in_vld     (sel_in_vld),
      .in_data    (sel_in),
      .out_vld    (sel_vld),
      .out_median (sel_med)
   );

`ifdef MAD_OUTLIER_EN
   localparam int KW = DATA_WIDTH + $clog2(OUTLIER_K + 1);
   logic is_outlier;
   assign is_outlier = KW'(dev) > (KW'(mad_raw) * KW'(OUTLIER_K));
`else
   assign outlier_cnt = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         rd_req     <= 1'b0;
         rd_ch      <= '0;
         rd_addr    <= '0;
         beat_cnt   <= '0;
         median     <= '0;
         mad_raw    <= '0;
         mad_scaled <= '0;
         below_cnt  <= '0;
`ifdef MAD_OUTLIER_EN
         outlier_cnt <= '0;
`endif
      end else begin
         done <= 1'b0;

         // Request issue runs independently of beat counting: once started
         // it walks 0..POPSIZE-1 back-to-back and parks at address 0.
         if (rd_req) begin
            if (rd_addr == AW'(POPSIZE - 1)) begin
               rd_req  <= 1'b0;
               rd_addr <= '0;
            end else begin
               rd_addr <= rd_addr + AW'(1);
            end
         end

         if (in_pass && rd_vld)
            beat_cnt <= last_beat ? CW'(0) : (beat_cnt + CW'(1));

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_MED_PASS;
                  busy      <= 1'b1;
                  rd_ch     <= ch_sel;
                  rd_req    <= 1'b1;
                  rd_addr   <= '0;
                  beat_cnt  <= '0;
                  below_cnt <= '0;
`ifdef MAD_OUTLIER_EN
                  outlier_cnt <= '0;
`endif
               end
            end
            ST_MED_PASS: begin
               if (last_beat)
                  state <= ST_MED_WAIT;
            end
            ST_MED_WAIT: begin
               if (sel_vld) begin
                  median <= sel_med;
                  state  <= ST_DEV_PASS;
                  rd_req <= 1'b1;
               end
            end
            ST_DEV_PASS: begin
               if (rd_vld && (rd_data < median))
                  below_cnt <= below_cnt + CW'(1);
               if (last_beat)
                  state <= ST_DEV_WAIT;
            end
            ST_DEV_WAIT: begin
               if (sel_vld) begin
                  mad_raw <= sel_med;
                  state   <= ST_SCALE;
               end
            end
            ST_SCALE: begin
               mad_scaled <= SW'(mad_raw) * SW'(SCALE);
`ifdef MAD_OUTLIER_EN
               state  <= ST_OUT_PASS;
               rd_req <= 1'b1;
`else
               state <= ST_DONE;
               done  <= 1'b1;
               busy  <= 1'b0;
`endif
            end
`ifdef MAD_OUTLIER_EN
            ST_OUT_PASS: begin
               if (rd_vld && is_outlier)
                  outlier_cnt <= outlier_cnt + CW'(1);
               if (last_beat) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
`endif
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mad_engine.sv
// Self-checking bench for mad_engine. Three instances share one memory model,
// selected by 'which': A (8b, POPSIZE 5), B (12b, POPSIZE 4), C (defaults).
module tb_mad_engine;

`ifdef MAD_OUTLIER_EN
   localparam int OE = 1;
`else
   localparam int OE = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  ch_sel;
   logic        rd_vld;
   logic [11:0] rd_data;
   int          which;

   always #5 clk = ~clk;

   // instance A
   logic a_start, a_vld, a_busy, a_done, a_req;
   logic [1:0] a_ch;  logic [2:0] a_addr;
   logic [7:0] a_med, a_mad; logic [23:0] a_sc; logic [2:0] a_below, a_outl;
   // instance B
   logic b_start, b_vld, b_busy, b_done, b_req;
   logic [0:0] b_chsel, b_ch; logic [1:0] b_addr;
   logic [11:0] b_med, b_mad; logic [27:0] b_sc; logic [2:0] b_below, b_outl;
   // instance C
   logic c_start, c_vld, c_busy, c_done, c_req;
   logic [1:0] c_ch;  logic [6:0] c_addr;
   logic [7:0] c_med, c_mad; logic [23:0] c_sc; logic [6:0] c_below, c_outl;

   assign a_start = start && (which == 0);
   assign b_start = start && (which == 1);
   assign c_start = start && (which == 2);
   assign a_vld   = rd_vld && (which == 0);
   assign b_vld   = rd_vld && (which == 1);
   assign c_vld   = rd_vld && (which == 2);
   assign b_chsel = ch_sel[0];

   mad_engine #(.DATA_WIDTH(8), .POPSIZE(5), .NUM_CH(4)) u_a (
      .clk(clk), .rst(rst), .start(a_start), .ch_sel(ch_sel), .busy(a_busy), .done(a_done),
      .rd_req(a_req), .rd_ch(a_ch), .rd_addr(a_addr), .rd_vld(a_vld), .rd_data(rd_data[7:0]),
      .median(a_med), .mad_raw(a_mad), .mad_scaled(a_sc), .below_cnt(a_below), .outlier_cnt(a_outl));

   mad_engine #(.DATA_WIDTH(12), .POPSIZE(4), .NUM_CH(2)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .ch_sel(b_chsel), .busy(b_busy), .done(b_done),
      .rd_req(b_req), .rd_ch(b_ch), .rd_addr(b_addr), .rd_vld(b_vld), .rd_data(rd_data),
      .median(b_med), .mad_raw(b_mad), .mad_scaled(b_sc), .below_cnt(b_below), .outlier_cnt(b_outl));

   mad_engine u_c (
      .clk(clk), .rst(rst), .start(c_start), .ch_sel(ch_sel), .busy(c_busy), .done(c_done),
      .rd_req(c_req), .rd_ch(c_ch), .rd_addr(c_addr), .rd_vld(c_vld), .rd_data(rd_data[7:0]),
      .median(c_med), .mad_raw(c_mad), .mad_scaled(c_sc), .below_cnt(c_below), .outlier_cnt(c_outl));

   // outputs of the selected instance
   longint m_busy, m_done, m_req, m_med, m_mad, m_sc, m_below, m_outl;
   int     m_ch, m_addr;

   always_comb begin
      m_busy = 0; m_done = 0; m_req = 0; m_med = 0; m_mad = 0; m_sc = 0;
      m_below = 0; m_outl = 0; m_ch = 0; m_addr = 0;
      case (which)
         0: begin
            m_busy = longint'(a_busy); m_done = longint'(a_done); m_req = longint'(a_req);
            m_med = longint'(a_med); m_mad = longint'(a_mad); m_sc = longint'(a_sc);
            m_below = longint'(a_below); m_outl = longint'(a_outl);
            m_ch = int'(a_ch); m_addr = int'(a_addr);
         end
         1: begin
            m_busy = longint'(b_busy); m_done = longint'(b_done); m_req = longint'(b_req);
            m_med = longint'(b_med); m_mad = longint'(b_mad); m_sc = longint'(b_sc);
            m_below = longint'(b_below); m_outl = longint'(b_outl);
            m_ch = int'(b_ch); m_addr = int'(b_addr);
         end
         default: begin
            m_busy = longint'(c_busy); m_done = longint'(c_done); m_req = longint'(c_req);
            m_med = longint'(c_med); m_mad = longint'(c_mad); m_sc = longint'(c_sc);
            m_below = longint'(c_below); m_outl = longint'(c_outl);
            m_ch = int'(c_ch); m_addr = int'(c_addr);
         end
      endcase
   end

   // memory model: in-order responses, configurable latency and random gaps
   typedef struct { int due; int data; } beat_t;
   beat_t       q[$];
   int          mem [4][100];
   int          lat = 0, gap_pct = 0, cyc = 0;
   logic        mv = 1'b0, stray = 1'b0;
   logic [11:0] md = '0;

   assign rd_vld  = mv | stray;
   assign rd_data = stray ? 12'hABC : md;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         q.delete();
         mv <= 1'b0;
      end else begin
         if (m_req != 0) q.push_back('{cyc + lat, mem[m_ch][m_addr]});
         if (q.size() > 0 && q[0].due <= cyc && int'($urandom_range(99)) >= gap_pct) begin
            mv <= 1'b1;
            md <= 12'(q[0].data);
            q.delete(0);
         end else begin
            mv <= 1'b0;
         end
      end
   end

   // protocol monitor
   int     req_cnt = 0, ch_bad = 0, exp_ch = 0;
   longint last_beat_t = 0;
   always @(negedge clk) begin
      if (m_req != 0) begin
         req_cnt <= req_cnt + 1;
         if (m_ch != exp_ch) ch_bad <= ch_bad + 1;
      end
   end
   always @(posedge clk) if (rd_vld) last_beat_t <= longint'($time);

   int n_vec = 0, n_err = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // reference model: sort-based medians over the sample list
   int smp [100];
   function automatic void model(input int n, output int med, output int mad,
                                 output int below, output int outl);
      int v[$];
      int d[$];
      int dv;
      for (int i = 0; i < n; i++) v.push_back(smp[i]);
      v.sort();
      med = v[(n - 1) / 2];
      below = 0;
      for (int i = 0; i < n; i++) begin
         dv = (smp[i] > med) ? smp[i] - med : med - smp[i];
         d.push_back(dv);
         if (smp[i] < med) below++;
      end
      d.sort();
      mad = d[(n - 1) / 2];
      outl = 0;
      for (int i = 0; i < n; i++) if (d[i] > 3 * mad) outl++;
      if (OE == 0) outl = 0;
   endfunction

   longint o_med, o_mad, o_sc, o_below, o_outl;

   // one complete run on instance 'inst' using smp[0..n-1] on channel ch
   task automatic run(input string tag, input int inst, input int ch, input int n,
                      input int l, input int g, input bit poke);
      int     r_req, r_bad, maxv;
      longint t_done;
      which = inst; lat = l; gap_pct = g; exp_ch = ch;
      maxv = (inst == 1) ? 4095 : 255;
      for (int c = 0; c < 4; c++)
         for (int a = 0; a < 100; a++)
            mem[c][a] = (c == ch && a < n) ? smp[a] : int'($urandom_range(maxv));
      @(negedge clk);
      r_req = req_cnt; r_bad = ch_bad;
      start = 1'b1; ch_sel = 2'(ch);
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy_start"}, m_busy, 1);
      t_done = 0;
      for (int c = 0; c < 4000; c++) begin
         start = poke && (c == 6 || c == 7);
         if (poke) ch_sel = 2'(ch ^ 1);
         @(negedge clk);
         if (m_done != 0) begin
            t_done = longint'($time);
            break;
         end
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, (t_done != 0) ? 1 : 0, 1);
      o_med = m_med; o_mad = m_mad; o_sc = m_sc; o_below = m_below; o_outl = m_outl;
      chk({tag, "_busy_at_done"}, m_busy, 0);
      chk({tag, "_beat_before_done"}, (last_beat_t < t_done) ? 1 : 0, 1);
      chk({tag, "_req_count"}, longint'(req_cnt - r_req), longint'((2 + OE) * n));
      chk({tag, "_rd_ch"}, longint'(ch_bad - r_bad), 0);
      // start held during the done cycle must be ignored
      start = poke;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_done_1cyc"}, m_done, 0);
      chk({tag, "_idle_after"}, m_busy, 0);
   endtask

   task automatic check_res(input string tag, input int med, input int mad,
                            input longint sc, input int below, input int outl);
      chk({tag, "_median"}, o_med, longint'(med));
      chk({tag, "_mad_raw"}, o_mad, longint'(mad));
      chk({tag, "_mad_scaled"}, o_sc, sc);
      chk({tag, "_below_cnt"}, o_below, longint'(below));
      chk({tag, "_outlier_cnt"}, o_outl, longint'(outl));
   endtask

   typedef struct {
      int inst; int ch; int lat; int gap; int n; int s[5]; int fill;
      int med; int mad; longint sc; int below; int outl; bit poke;
   } vec_t;
   vec_t tbl[9];

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int med, mad, below, outl, inst, n, dw_max, ch;
      rst = 1'b1; start = 1'b0; ch_sel = '0; which = 0;

      tbl[0] = '{0, 1, 0, 0,  5, '{3, 7, 1, 9, 5},          0,  5,   2,   760, 2, 0,  1'b0};
      tbl[1] = '{0, 1, 7, 30, 5, '{3, 7, 1, 9, 5},          0,  5,   2,   760, 2, 0,  1'b0};
      tbl[2] = '{2, 2, 2, 10, 100, '{0, 0, 0, 0, 0},        10, 10,  0,   0,   0, 0,  1'b0};
      tbl[3] = '{0, 3, 3, 0,  5, '{10, 10, 10, 10, 200},    0,  10,  0,   0,   0, OE, 1'b0};
      tbl[4] = '{1, 1, 0, 0,  4, '{8, 2, 6, 4, 0},          0,  4,   2,   760, 1, 0,  1'b0};
      tbl[5] = '{1, 0, 5, 20, 4, '{1000, 1100, 1300, 1400, 0}, 0, 1100, 100, 38000, 1, 0, 1'b0};
      tbl[6] = '{1, 1, 1, 0,  4, '{0, 0, 0, 4095, 0},       0,  0,   0,   0,   0, OE, 1'b0};
      tbl[7] = '{0, 0, 0, 0,  5, '{0, 255, 255, 0, 128},    0,  128, 127, 48260, 2, 0, 1'b0};
      tbl[8] = '{0, 2, 0, 0,  5, '{3, 7, 1, 9, 5},          0,  5,   2,   760, 2, 0,  1'b1};

      repeat (3) @(negedge clk);
      chk("rst_busy", m_busy, 0);
      chk("rst_done", m_done, 0);
      chk("rst_rd_req", m_req, 0);
      chk("rst_median", m_med, 0);
      chk("rst_mad_raw", m_mad, 0);
      chk("rst_mad_scaled", m_sc, 0);
      chk("rst_below", m_below, 0);
      chk("rst_outlier", m_outl, 0);
      rst = 1'b0;
      @(negedge clk);

      foreach (tbl[i]) begin
         for (int k = 0; k < 100; k++) begin
            if (k < 5 && tbl[i].n <= 5) smp[k] = tbl[i].s[k];
            else smp[k] = tbl[i].fill;
         end
         run($sformatf("t%0d", i), tbl[i].inst, tbl[i].ch, tbl[i].n,
             tbl[i].lat, tbl[i].gap, tbl[i].poke);
         check_res($sformatf("t%0d", i), tbl[i].med, tbl[i].mad, tbl[i].sc,
                   tbl[i].below, tbl[i].outl);
      end

      // reset in the middle of the median pass on instance A
      which = 0; exp_ch = 1; lat = 2; gap_pct = 0;
      for (int a = 0; a < 5; a++) mem[1][a] = 50 + a;
      start = 1'b1; ch_sel = 2'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", m_busy, 0);
      chk("midrst_rd_req", m_req, 0);
      chk("midrst_median", m_med, 0);
      chk("midrst_mad_scaled", m_sc, 0);
      rst = 1'b0;
      begin
         int dcnt = 0;
         for (int c = 0; c < 20; c++) begin
            stray = (c >= 4 && c < 8);
            @(negedge clk);
            if (m_done != 0) dcnt++;
         end
         stray = 1'b0;
         chk("midrst_no_done", longint'(dcnt), 0);
         chk("stray_idle_busy", m_busy, 0);
      end
      smp[0] = 20; smp[1] = 4; smp[2] = 11; smp[3] = 17; smp[4] = 9;
      model(5, med, mad, below, outl);
      run("post_rst", 0, 1, 5, 4, 25, 1'b0);
      check_res("post_rst", med, mad, longint'(mad) * 380, below, outl);

      // randomized runs against the reference model
      for (int r = 0; r < 12; r++) begin
         inst = r % 3;
         n = (inst == 0) ? 5 : (inst == 1) ? 4 : 100;
         dw_max = (inst == 1) ? 4095 : 255;
         ch = (inst == 1) ? int'($urandom_range(1)) : int'($urandom_range(3));
         for (int k = 0; k < 100; k++)
            smp[k] = (r % 2 == 0) ? int'($urandom_range(dw_max))
                                  : int'($urandom_range(dw_max / 2 + 3, dw_max / 2 - 3));
         model(n, med, mad, below, outl);
         run($sformatf("r%0d", r), inst, ch, n, int'($urandom_range(7)),
             int'($urandom_range(40)), (r % 4 == 1));
         check_res($sformatf("r%0d", r), med, mad, longint'(mad) * 380, below, outl);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
